// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg
// Shared types and constants for the instruction-fetch controller.
//   fetch_state_e : controller states (HALT is reachable only when
//                   FETCH_CTRL_MISALIGN_EN is defined)
//   pc_sel_e      : program-counter update select
//   INST_BYTES    : size of one instruction word in bytes
//   XLEN_DEFAULT / RESET_PC_DEFAULT : default parameter values
package fetch_ctrl_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam logic [XLEN_DEFAULT-1:0] RESET_PC_DEFAULT = 32'h0;
    localparam int INST_BYTES = 4;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        HALT
    } fetch_state_e;

    typedef enum logic [1:0] {
        PC_HOLD,
        PC_INC,
        PC_LOAD
    } pc_sel_e;

endpackage

// File: rtl/fetch_pc_reg.sv
// fetch_pc_reg
// Program-counter register with hold / increment / load-target select.
// Both adders wrap modulo 2^XLEN.
// Configuration macro: FETCH_CTRL_MISALIGN_EN
//   defined   : target loaded as computed; misaligned_o flags bits [1:0] != 0
//   undefined : target bits [1:0] forced to zero, no misaligned_o port
// Ports:
//   clock, reset          clock, asynchronous active-high reset
//   sel_i                 PC_HOLD / PC_INC / PC_LOAD
//   redirect_pc_i/imm_i   branch PC and offset forming the load target
//   misaligned_o          redirect target not word aligned (macro only)
//   pc_o                  current program counter
module fetch_pc_reg
    import fetch_ctrl_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clock,
    input  logic            reset,
    input  pc_sel_e         sel_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic [XLEN-1:0] redirect_imm_i,
`ifdef FETCH_CTRL_MISALIGN_EN
    output logic            misaligned_o,
`endif
    output logic [XLEN-1:0] pc_o
);

`ifdef FETCH_CTRL_MISALIGN_EN
    localparam logic [XLEN-1:0] TARGET_MASK = '1;
`else
    localparam logic [XLEN-1:0] TARGET_MASK = ~XLEN'(INST_BYTES - 1);
`endif

    logic [XLEN-1:0] target;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] pc_q;

    // Sum is truncated to XLEN bits, so the carry out is dropped (wrap).
    assign target = (redirect_pc_i + redirect_imm_i) & TARGET_MASK;

`ifdef FETCH_CTRL_MISALIGN_EN
    assign misaligned_o = (target[1:0] != 2'b00);
`endif

    always_comb begin
        pc_d = pc_q;
        unique case (sel_i)
            PC_INC:  pc_d = pc_q + XLEN'(INST_BYTES);
            PC_LOAD: pc_d = target;
            default: pc_d = pc_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl
// Instruction-fetch sequencing controller. Issues one memory request at a
// time, buffers the returned instruction for decode and applies branch
// redirects, discarding responses that belong to a squashed request.
// Configuration macro: FETCH_CTRL_MISALIGN_EN (misaligned redirect -> HALT).
// Ports:
//   clock, reset                 clock, asynchronous active-high reset
//   io_imem_req_*                request handshake and address (= pc)
//   io_imem_resp_*               response valid and instruction word
//   io_inst_valid/ready, io_inst, io_inst_pc   buffered instruction to decode
//   io_redirect_valid/pc/imm     taken branch; target = pc + imm
//   io_exc_misaligned            in HALT after a misaligned redirect
// Every output comes from a register or from the registered state.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clock,
    input  logic            reset,
    output logic            io_imem_req_valid,
    input  logic            io_imem_req_ready,
    output logic [XLEN-1:0] io_imem_req_addr,
    input  logic            io_imem_resp_valid,
    input  logic [XLEN-1:0] io_imem_resp_data,
    output logic            io_inst_valid,
    input  logic            io_inst_ready,
    output logic [XLEN-1:0] io_inst,
    output logic [XLEN-1:0] io_inst_pc,
    input  logic            io_redirect_valid,
    input  logic [XLEN-1:0] io_redirect_pc,
    input  logic [XLEN-1:0] io_redirect_imm,
    output logic            io_exc_misaligned
);

    fetch_state_e    state_d, state_q;
    logic            kill_d, kill_q;
    logic [XLEN-1:0] inst_d, inst_q;
    logic [XLEN-1:0] inst_pc_d, inst_pc_q;
    pc_sel_e         pc_sel;
    logic [XLEN-1:0] pc;
    logic            redirect_misaligned;

    fetch_pc_reg #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clock          (clock),
        .reset          (reset),
        .sel_i          (pc_sel),
        .redirect_pc_i  (io_redirect_pc),
        .redirect_imm_i (io_redirect_imm),
`ifdef FETCH_CTRL_MISALIGN_EN
        .misaligned_o   (redirect_misaligned),
`endif
        .pc_o           (pc)
    );

`ifndef FETCH_CTRL_MISALIGN_EN
    assign redirect_misaligned = 1'b0;
`endif

    // NOTE: every variable written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        kill_d    = kill_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        pc_sel    = PC_HOLD;

        unique case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (io_imem_req_ready) begin
                    state_d = WAIT;
                    // Old-address request already accepted: squash its response.
                    kill_d  = io_redirect_valid;
                end
            end
            WAIT: begin
                if (io_redirect_valid) begin
                    // A same-cycle response is stale; otherwise wait and drop it.
                    if (io_imem_resp_valid) begin
                        state_d = REQ;
                        kill_d  = 1'b0;
                    end else begin
                        kill_d  = 1'b1;
                    end
                end else if (io_imem_resp_valid) begin
                    if (kill_q) begin
                        kill_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        inst_d    = io_imem_resp_data;
                        inst_pc_d = pc;
                        pc_sel    = PC_INC;
                        state_d   = HOLD;
                    end
                end
            end
            HOLD: begin
                if (io_inst_ready || io_redirect_valid) begin
                    state_d = REQ;
                end
            end
            HALT: state_d = HALT;
            default: state_d = IDLE;
        endcase

        // Redirect overrides the pc update in every live state.
        if (io_redirect_valid && (state_q != HALT)) begin
            if (redirect_misaligned) begin
                state_d = HALT;
                kill_d  = 1'b0;
                pc_sel  = PC_HOLD;
            end else begin
                pc_sel  = PC_LOAD;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            kill_q    <= 1'b0;
            inst_q    <= '0;
            inst_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            kill_q    <= kill_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
        end
    end

    assign io_imem_req_valid = (state_q == REQ);
    assign io_imem_req_addr  = pc;
    assign io_inst_valid     = (state_q == HOLD);
    assign io_inst           = inst_q;
    assign io_inst_pc        = inst_pc_q;

`ifdef FETCH_CTRL_MISALIGN_EN
    assign io_exc_misaligned = (state_q == HALT);
`else
    assign io_exc_misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl
// Self-checking bench for fetch_ctrl. A memory model answers accepted
// requests after a programmable latency; a scoreboard of expected
// {pc, inst} pairs is filled when fetches are driven and drained when decode
// handshakes an instruction.
module tb_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          edge_n;
    } acc_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        io_imem_req_valid;
    logic        io_imem_req_ready = 1'b0;
    logic [31:0] io_imem_req_addr;
    logic        io_imem_resp_valid = 1'b0;
    logic [31:0] io_imem_resp_data = 32'h0;
    logic        io_inst_valid;
    logic        io_inst_ready = 1'b0;
    logic [31:0] io_inst;
    logic [31:0] io_inst_pc;
    logic        io_redirect_valid = 1'b0;
    logic [31:0] io_redirect_pc = 32'h0;
    logic [31:0] io_redirect_imm = 32'h0;
    logic        io_exc_misaligned;

    int total = 0;
    int bad   = 0;
    int edge_n = 0;

    exp_t exp_q[$];
    acc_t acc_q[$];
    int   hs_q[$];
    exp_t sb_e;

    int          mem_lat = 1;
    logic        mem_ovr = 1'b0;
    logic [31:0] mem_ovr_data = 32'h0;
    logic        m_acc;
    int          m_lat;
    int          m_cnt = 0;
    logic [31:0] m_word;
    logic [31:0] m_data;

    fetch_ctrl dut (
        .clock              (clock),
        .reset              (reset),
        .io_imem_req_valid  (io_imem_req_valid),
        .io_imem_req_ready  (io_imem_req_ready),
        .io_imem_req_addr   (io_imem_req_addr),
        .io_imem_resp_valid (io_imem_resp_valid),
        .io_imem_resp_data  (io_imem_resp_data),
        .io_inst_valid      (io_inst_valid),
        .io_inst_ready      (io_inst_ready),
        .io_inst            (io_inst),
        .io_inst_pc         (io_inst_pc),
        .io_redirect_valid  (io_redirect_valid),
        .io_redirect_pc     (io_redirect_pc),
        .io_redirect_imm    (io_redirect_imm),
        .io_exc_misaligned  (io_exc_misaligned)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_1234;
    endfunction

    // Instruction memory: answers an accepted request mem_lat cycles later.
    always begin
        @(posedge clock);
        m_acc  = io_imem_req_valid && io_imem_req_ready && !reset;
        m_lat  = mem_lat;
        m_word = mem_ovr ? mem_ovr_data : mem_word(io_imem_req_addr);
        #1;
        io_imem_resp_valid = 1'b0;
        if (m_acc) begin
            m_cnt  = m_lat;
            m_data = m_word;
        end
        if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
                io_imem_resp_valid = 1'b1;
                io_imem_resp_data  = m_data;
            end
        end
    end

    // Monitor: logs request accepts and checks decode handshakes against the scoreboard.
    always @(posedge clock) begin
        if (!reset) begin
            if (io_imem_req_valid && io_imem_req_ready) begin
                acc_q.push_back('{addr: io_imem_req_addr, edge_n: edge_n});
            end
            if (io_inst_valid && io_inst_ready) begin
                hs_q.push_back(edge_n);
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL sb_extra: got pc=%h inst=%h, required no instruction", io_inst_pc, io_inst);
                end else begin
                    sb_e = exp_q.pop_front();
                    if (io_inst !== sb_e.inst || io_inst_pc !== sb_e.pc) begin
                        bad++;
                        $display("FAIL sb_inst: got pc=%h inst=%h, required pc=%h inst=%h",
                                 io_inst_pc, io_inst, sb_e.pc, sb_e.inst);
                    end
                end
            end
        end
        edge_n++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (io_imem_req_valid !== 1'b1 && n < 20) begin
            cyc();
            n++;
        end
        total++;
        if (io_imem_req_valid !== 1'b1) begin
            bad++;
            $display("FAIL %s_req_timeout: req_valid=%b, required 1", tag, io_imem_req_valid);
        end
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            cyc();
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: %0d instructions outstanding, required 0", tag, exp_q.size());
        end
    endtask

    task automatic fetch_one(input string tag, input logic [31:0] addr);
        exp_t e;
        wait_req(tag);
        total++;
        if (io_imem_req_addr !== addr) begin
            bad++;
            $display("FAIL %s_addr: got %h, required %h", tag, io_imem_req_addr, addr);
        end
        e.pc   = addr;
        e.inst = mem_word(addr);
        exp_q.push_back(e);
        io_imem_req_ready = 1'b1;
        cyc();
        io_imem_req_ready = 1'b0;
        drain(tag);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc(3);
        total++;
        if ({io_imem_req_valid, io_inst_valid, io_exc_misaligned} !== 3'b000) begin
            bad++;
            $display("FAIL reset_ctrl: req/inst/exc=%b, required 000",
                     {io_imem_req_valid, io_inst_valid, io_exc_misaligned});
        end
        total++;
        if ({io_imem_req_addr, io_inst, io_inst_pc} !== {RESET_PC, 32'h0, 32'h0}) begin
            bad++;
            $display("FAIL reset_data: addr=%h inst=%h inst_pc=%h, required %h 0 0",
                     io_imem_req_addr, io_inst, io_inst_pc, RESET_PC);
        end
        reset = 1'b0;
        cyc();
        total++;
        if (io_imem_req_valid !== 1'b1 || io_imem_req_addr !== RESET_PC) begin
            bad++;
            $display("FAIL reset_first_req: valid=%b addr=%h, required 1 %h",
                     io_imem_req_valid, io_imem_req_addr, RESET_PC);
        end
    endtask

    task automatic test_stream();
        exp_t e;
        acc_q.delete();
        hs_q.delete();
        for (int i = 0; i < 4; i++) begin
            e.pc   = 32'(i * 4);
            e.inst = mem_word(32'(i * 4));
            exp_q.push_back(e);
        end
        io_inst_ready     = 1'b1;
        io_imem_req_ready = 1'b1;
        for (int n = 0; n < 60 && hs_q.size() < 4; n++) begin
            cyc();
            if (acc_q.size() >= 4) io_imem_req_ready = 1'b0;
        end
        io_imem_req_ready = 1'b0;
        total++;
        if (acc_q.size() != 4 || hs_q.size() != 4) begin
            bad++;
            $display("FAIL stream_count: accepts=%0d handshakes=%0d, required 4 4", acc_q.size(), hs_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (acc_q[i].addr !== 32'(i * 4)) begin
                    bad++;
                    $display("FAIL stream_addr%0d: got %h, required %h", i, acc_q[i].addr, 32'(i * 4));
                end
                total++;
                if (hs_q[i] - acc_q[i].edge_n != 2) begin
                    bad++;
                    $display("FAIL stream_latency%0d: got %0d cycles, required 2", i, hs_q[i] - acc_q[i].edge_n);
                end
            end
            for (int i = 0; i < 3; i++) begin
                total++;
                if (acc_q[i + 1].edge_n - acc_q[i].edge_n != 3) begin
                    bad++;
                    $display("FAIL stream_rate%0d: got %0d cycles, required 3", i,
                             acc_q[i + 1].edge_n - acc_q[i].edge_n);
                end
            end
        end
        drain("stream");
    endtask

    task automatic test_ready_stall();
        exp_t e;
        acc_q.delete();
        wait_req("stall");
        for (int i = 0; i < 3; i++) begin
            total++;
            if (io_imem_req_valid !== 1'b1 || io_imem_req_addr !== 32'h10) begin
                bad++;
                $display("FAIL stall_hold%0d: valid=%b addr=%h, required 1 00000010",
                         i, io_imem_req_valid, io_imem_req_addr);
            end
            cyc();
        end
        e.pc   = 32'h10;
        e.inst = mem_word(32'h10);
        exp_q.push_back(e);
        io_imem_req_ready = 1'b1;
        cyc();
        io_imem_req_ready = 1'b0;
        total++;
        if (acc_q.size() != 1 || acc_q[0].addr !== 32'h10) begin
            bad++;
            $display("FAIL stall_accept: accepts=%0d, required one at 00000010", acc_q.size());
        end
        drain("stall");
    endtask

    task automatic test_redirect_wait();
        wait_req("rdw");
        total++;
        if (io_imem_req_addr !== 32'h14) begin
            bad++;
            $display("FAIL rdw_pre_addr: got %h, required 00000014", io_imem_req_addr);
        end
        mem_lat      = 3;
        mem_ovr      = 1'b1;
        mem_ovr_data = 32'hDEAD_BEEF;
        io_imem_req_ready = 1'b1;
        cyc();
        io_imem_req_ready = 1'b0;
        io_redirect_valid = 1'b1;
        io_redirect_pc    = 32'h100;
        io_redirect_imm   = 32'h20;
        cyc();
        io_redirect_valid = 1'b0;
        mem_ovr = 1'b0;
        mem_lat = 1;
        total++;
        if (io_imem_req_valid !== 1'b0 || io_inst_valid !== 1'b0) begin
            bad++;
            $display("FAIL rdw_waiting: req_valid=%b inst_valid=%b, required 0 0", io_imem_req_valid, io_inst_valid);
        end
        fetch_one("rdw", 32'h120);
    endtask

    task automatic test_redirect_req();
        acc_q.delete();
        wait_req("rdr");
        io_imem_req_ready = 1'b1;
        io_redirect_valid = 1'b1;
        io_redirect_pc    = 32'h300;
        io_redirect_imm   = 32'h40;
        cyc();
        io_imem_req_ready = 1'b0;
        io_redirect_valid = 1'b0;
        total++;
        if (acc_q.size() != 1 || acc_q[0].addr !== 32'h124) begin
            bad++;
            $display("FAIL rdr_old_accept: accepts=%0d, required one at 00000124", acc_q.size());
        end
        fetch_one("rdr", 32'h340);
    endtask

    task automatic test_redirect_wrap();
        wait_req("wrap");
        io_redirect_valid = 1'b1;
        io_redirect_pc    = 32'hFFFF_FFF0;
        io_redirect_imm   = 32'h20;
        cyc();
        total++;
        if (io_imem_req_valid !== 1'b1 || io_imem_req_addr !== 32'h10) begin
            bad++;
            $display("FAIL wrap_target: valid=%b addr=%h, required 1 00000010", io_imem_req_valid, io_imem_req_addr);
        end
        io_redirect_imm = 32'hC;
        cyc();
        io_redirect_valid = 1'b0;
        fetch_one("wrap_top", 32'hFFFF_FFFC);
        wait_req("wrap_inc");
        total++;
        if (io_imem_req_addr !== 32'h0) begin
            bad++;
            $display("FAIL wrap_inc: got %h, required 00000000", io_imem_req_addr);
        end
    endtask

    task automatic test_hold();
        exp_t e;
        int   n = 0;
        io_inst_ready = 1'b0;
        wait_req("hold");
        e.pc   = 32'h0;
        e.inst = mem_word(32'h0);
        exp_q.push_back(e);
        io_imem_req_ready = 1'b1;
        cyc();
        io_imem_req_ready = 1'b0;
        while (io_inst_valid !== 1'b1 && n < 10) begin
            cyc();
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            total++;
            if ({io_inst_valid, io_inst, io_inst_pc} !== {1'b1, mem_word(32'h0), 32'h0}) begin
                bad++;
                $display("FAIL hold_stable%0d: valid=%b inst=%h pc=%h, required 1 %h 00000000",
                         i, io_inst_valid, io_inst, io_inst_pc, mem_word(32'h0));
            end
            cyc();
        end
        io_inst_ready     = 1'b1;
        io_redirect_valid = 1'b1;
        io_redirect_pc    = 32'h1F0;
        io_redirect_imm   = 32'h10;
        cyc();
        io_redirect_valid = 1'b0;
        total++;
        if ({io_inst_valid, io_imem_req_valid, io_imem_req_addr} !== {1'b0, 1'b1, 32'h200}) begin
            bad++;
            $display("FAIL hold_redirect: inst_valid=%b req_valid=%b addr=%h, required 0 1 00000200",
                     io_inst_valid, io_imem_req_valid, io_imem_req_addr);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL hold_handshake: %0d outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_misalign();
        acc_q.delete();
        wait_req("mis");
        io_redirect_valid = 1'b1;
        io_redirect_pc    = 32'h100;
        io_redirect_imm   = 32'h2;
        cyc();
        io_redirect_valid = 1'b0;
`ifdef FETCH_CTRL_MISALIGN_EN
        total++;
        if ({io_exc_misaligned, io_imem_req_valid, io_inst_valid} !== 3'b100) begin
            bad++;
            $display("FAIL mis_halt: exc/req/inst=%b, required 100",
                     {io_exc_misaligned, io_imem_req_valid, io_inst_valid});
        end
        io_imem_req_ready = 1'b1;
        cyc(5);
        io_imem_req_ready = 1'b0;
        total++;
        if (io_exc_misaligned !== 1'b1 || acc_q.size() != 0) begin
            bad++;
            $display("FAIL mis_stuck: exc=%b accepts=%0d, required 1 0", io_exc_misaligned, acc_q.size());
        end
        reset = 1'b1;
        #1;
        total++;
        if (io_exc_misaligned !== 1'b0 || io_imem_req_addr !== RESET_PC) begin
            bad++;
            $display("FAIL mis_reset: exc=%b addr=%h, required 0 %h", io_exc_misaligned, io_imem_req_addr, RESET_PC);
        end
        cyc();
        reset = 1'b0;
        fetch_one("mis_after", RESET_PC);
`else
        total++;
        if ({io_exc_misaligned, io_imem_req_valid, io_imem_req_addr} !== {1'b0, 1'b1, 32'h100}) begin
            bad++;
            $display("FAIL mis_mask: exc=%b valid=%b addr=%h, required 0 1 00000100",
                     io_exc_misaligned, io_imem_req_valid, io_imem_req_addr);
        end
        fetch_one("mis_mask", 32'h100);
`endif
    endtask

    task automatic test_async_reset();
        wait_req("ares");
        mem_lat = 3;
        io_imem_req_ready = 1'b1;
        cyc();
        io_imem_req_ready = 1'b0;
        mem_lat = 1;
        #3;
        reset = 1'b1;
        #1;
        total++;
        if ({io_imem_req_valid, io_inst_valid, io_exc_misaligned, io_imem_req_addr, io_inst, io_inst_pc}
            !== {3'b000, RESET_PC, 32'h0, 32'h0}) begin
            bad++;
            $display("FAIL ares_async: req=%b inst_valid=%b addr=%h inst=%h pc=%h, required 0 0 %h 0 0",
                     io_imem_req_valid, io_inst_valid, io_imem_req_addr, io_inst, io_inst_pc, RESET_PC);
        end
        cyc();
        reset = 1'b0;
        cyc(3);
        fetch_one("ares_after", RESET_PC);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_ready_stall();
        test_redirect_wait();
        test_redirect_req();
        test_redirect_wrap();
        test_hold();
        test_misalign();
        test_async_reset();
        cyc(2);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL final_queue: %0d outstanding, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Sequencing controller for the instruction-fetch stage. Owns the program counter and issues one instruction-memory request at a time over a valid/ready handshake. Buffers the returned instruction for decode and applies branch redirects, discarding stale responses. Sits between the instruction memory port and decode, replacing the raw hold/branch/increment controls on the PC register with a full request/response sequence.

## Interface
- `XLEN`, 32: address and instruction width.
- `RESET_PC`, 32'h0: PC value loaded at reset.
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `io_imem_req_valid`  out  1  fetch request valid.
- `io_imem_req_ready`  in  1  memory accepts request.
- `io_imem_req_addr`  out  XLEN  fetch address (current PC).
- `io_imem_resp_valid`  in  1  response data valid; at most one per accepted request.
- `io_imem_resp_data`  in  XLEN  instruction word.
- `io_inst_valid`  out  1  buffered instruction valid to decode.
- `io_inst_ready`  in  1  decode consumes instruction.
- `io_inst`  out  XLEN  instruction word.
- `io_inst_pc`  out  XLEN  PC of `io_inst`.
- `io_redirect_valid`  in  1  branch taken; one-cycle pulse.
- `io_redirect_pc`  in  XLEN  PC of branch.
- `io_redirect_imm`  in  XLEN  branch offset.
- `io_exc_misaligned`  out  1  misaligned redirect target (only with macro; otherwise tied 0).

## Operation
- Reset: state IDLE, pc=RESET_PC, kill=0, all outputs 0 (`io_imem_req_addr`=RESET_PC, `io_inst`/`io_inst_pc`=0).
- State transitions:
  - IDLE→REQ unconditionally.
  - REQ: `io_imem_req_valid`=1, addr=pc. On ready, go to WAIT.
  - WAIT: on resp_valid with kill=0, capture data into `io_inst`, set `io_inst_pc`=pc, pc<=pc+4, go to HOLD. With kill=1, drop the response, clear kill, go to REQ.
  - HOLD: `io_inst_valid`=1, outputs stable. On ready, go to REQ.
- Redirect target = `io_redirect_pc` + `io_redirect_imm`, modulo 2^XLEN (wrap, no carry out). pc+4 wraps likewise (32'hFFFF_FFFC→0).
- Redirect has priority over every other event:
  - In IDLE: pc<=target.
  - In REQ without ready: pc<=target, stay REQ. The new address is presented next cycle; memory samples addr only on handshake.
  - In REQ with ready the same cycle: the request at the old address is accepted. Set kill=1, pc<=target, go to WAIT.
  - In WAIT (with or without resp_valid): pc<=target. Any response arriving that same cycle is dropped and the controller goes to REQ. Otherwise kill=1 and it stays in WAIT.
  - In HOLD: pc<=target, `io_inst_valid` drops next cycle, go to REQ. With inst_ready the same cycle, the handshake counts as completed.
- resp_valid outside WAIT is ignored.

## Timing
- All outputs are registered or decoded from registered state; there is no combinational input→output path.
- Minimum latency: request accept at cycle N, response at N+1, `io_inst_valid` at N+2. Steady-state best throughput is one instruction per 3 cycles.
- `io_imem_req_addr` is stable while valid and not ready, except after a redirect.
- Asserting reset mid-operation returns to IDLE immediately and asynchronously. An outstanding memory response after reset is ignored.

## Configuration
- `FETCH_CTRL_MISALIGN_EN`:
  - Defined: a redirect target with bits [1:0]≠0 loads nothing into pc and enters state HALT. In HALT, `io_exc_misaligned`=1, req_valid=0 and inst_valid=0 until reset.
  - Undefined: no HALT state, `io_exc_misaligned`=0, target bits [1:0] are forced to 0.

## Structure
- `fetch_ctrl_pkg` holds:
  - the state enum (IDLE, REQ, WAIT, HOLD, HALT);
  - `INST_BYTES`=4;
  - `XLEN_DEFAULT`;
  - the RESET_PC default.
- One sub-module `fetch_pc_reg`: pc register with async reset. It has a load-target / increment / hold select and performs the wrapping adders.

## Test plan
- Reset, ready always 1, response 1 cycle after accept → addresses 0,4,8 issued; `io_inst_pc` 0,4,8, each valid at accept+2.
- Hold ready=0 for 3 cycles in REQ → addr stays 0x10 and req_valid stays 1; accept on cycle 4.
- Redirect pc=0x100, imm=0x20 while in WAIT, then response 0xDEADBEEF → response dropped; next request addr=0x120.
- Redirect pc=0xFFFFFFF0, imm=0x20 → target wraps to 0x10.
- HOLD with inst_ready=0 for 5 cycles → `io_inst` and `io_inst_pc` unchanged. Redirect with inst_ready in the same cycle → inst_valid=0 next cycle, next addr=target.
- With `FETCH_CTRL_MISALIGN_EN`, redirect target 0x102 → `io_exc_misaligned`=1, no further requests. Assert reset → returns to RESET_PC.
